// File: rtl/shift_counter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_counter
//  Description : WIDTH-bit rotate/shift register with a modulo-WIDTH advance
//                counter, a serial output of the last bit shifted out and a
//                single-cycle wrap pulse every WIDTH enabled advances.
//                Every output comes straight from a flop.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_counter #(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 1,
    parameter int          SW          = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] count,
    output logic             ser_out,
    output logic [SW-1:0]    step,
    output logic             wrap
);

    // Mode encodings of the advance operation.
    localparam logic [1:0] c_MODE_ROL = 2'b00;
    localparam logic [1:0] c_MODE_ROR = 2'b01;
    localparam logic [1:0] c_MODE_SHL = 2'b10;
    localparam logic [1:0] c_MODE_SHR = 2'b11;

    // Reset value truncated to the register width.
    localparam logic [31:0]      c_RESET_FULL = 32'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_RESET      = c_RESET_FULL[WIDTH-1:0];

    // Last legal step value; the counter folds back to zero after it, which
    // keeps step bounded for non-power-of-two widths.
    localparam logic [SW-1:0] c_STEP_LAST = SW'(WIDTH - 1);
    localparam logic [SW-1:0] c_STEP_ONE  = SW'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_ser_out;
    logic [SW-1:0]    r_step;
    logic             r_wrap;

    logic [WIDTH-1:0] w_adv_count;
    logic             w_adv_ser_out;
    logic [SW-1:0]    w_adv_step;
    logic             w_adv_wrap;

    // Value the register takes if this cycle is an enabled advance.
    always_comb begin
        w_adv_count   = r_count;
        w_adv_ser_out = r_ser_out;
        case (mode)
            c_MODE_ROL: begin
                w_adv_count   = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
                w_adv_ser_out = r_count[WIDTH-1];
            end
            c_MODE_ROR: begin
                w_adv_count   = {r_count[0], r_count[WIDTH-1:1]};
                w_adv_ser_out = r_count[0];
            end
            c_MODE_SHL: begin
                w_adv_count   = {r_count[WIDTH-2:0], ser_in};
                w_adv_ser_out = r_count[WIDTH-1];
            end
            c_MODE_SHR: begin
                w_adv_count   = {ser_in, r_count[WIDTH-1:1]};
                w_adv_ser_out = r_count[0];
            end
            default: begin
                w_adv_count   = r_count;
                w_adv_ser_out = r_ser_out;
            end
        endcase
    end

    // Step counter wraps modulo WIDTH; the wrap flag marks the fold to zero.
    always_comb begin
        w_adv_step = r_step + c_STEP_ONE;
        w_adv_wrap = 1'b0;
        if (r_step == c_STEP_LAST) begin
            w_adv_step = '0;
            w_adv_wrap = 1'b1;
        end
    end

    // State register: reset beats load, load beats advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count   <= c_RESET;
            r_ser_out <= 1'b0;
            r_step    <= '0;
            r_wrap    <= 1'b0;
        end else if (load) begin
            r_count   <= data;
            r_ser_out <= 1'b0;
            r_step    <= '0;
            r_wrap    <= 1'b0;
        end else if (en) begin
            r_count   <= w_adv_count;
            r_ser_out <= w_adv_ser_out;
            r_step    <= w_adv_step;
            r_wrap    <= w_adv_wrap;
        end else begin
            r_wrap    <= 1'b0;
        end
    end

    assign count   = r_count;
    assign ser_out = r_ser_out;
    assign step    = r_step;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_shift_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_counter
//  Description : Scoreboard bench for shift_counter. Two instances (WIDTH=4
//                with RESET_VALUE=1, WIDTH=5 with RESET_VALUE=37 which
//                truncates to 5) share the stimulus; an arithmetic reference
//                model predicts each edge and a monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_counter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] data = '0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ser_in = 1'b0;

    logic [3:0]  count4;
    logic        ser_out4;
    logic [1:0]  step4;
    logic        wrap4;
    logic [4:0]  count5;
    logic        ser_out5;
    logic [2:0]  step5;
    logic        wrap5;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] c4;
        logic       o4;
        logic [1:0] s4;
        logic       w4;
        logic [4:0] c5;
        logic       o5;
        logic [2:0] s5;
        logic       w5;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state, index 0 -> width 4, index 1 -> width 5.
    int m_w[2]   = '{4, 5};
    int m_rv[2]  = '{1, 37};
    int m_cnt[2];
    int m_so[2];
    int m_adv[2];
    int m_wrap[2];

    always #5 clk = ~clk;

    shift_counter #(.WIDTH(4), .RESET_VALUE(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .load(load), .data(data[3:0]),
        .en(en), .mode(mode), .ser_in(ser_in),
        .count(count4), .ser_out(ser_out4), .step(step4), .wrap(wrap4)
    );

    shift_counter #(.WIDTH(5), .RESET_VALUE(37)) dut5 (
        .clk(clk), .reset_n(reset_n), .load(load), .data(data[4:0]),
        .en(en), .mode(mode), .ser_in(ser_in),
        .count(count5), .ser_out(ser_out5), .step(step5), .wrap(wrap5)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One edge of the behavioural model: count is an integer, rotations and
    // shifts are multiplications/divisions by two, step is advances mod W.
    function automatic void model_edge(input int k);
        int w, mask, msb, lsb, top;
        w    = m_w[k];
        mask = (1 << w) - 1;
        top  = 1 << (w - 1);
        if (!reset_n) begin
            m_cnt[k] = m_rv[k] & mask; m_so[k] = 0; m_adv[k] = 0; m_wrap[k] = 0;
        end else if (load) begin
            m_cnt[k] = int'(data) & mask; m_so[k] = 0; m_adv[k] = 0; m_wrap[k] = 0;
        end else if (en) begin
            msb = (m_cnt[k] / top) % 2;
            lsb = m_cnt[k] % 2;
            case (mode)
                2'b00: begin m_cnt[k] = (m_cnt[k] * 2 + msb) & mask;           m_so[k] = msb; end
                2'b01: begin m_cnt[k] = m_cnt[k] / 2 + lsb * top;              m_so[k] = lsb; end
                2'b10: begin m_cnt[k] = (m_cnt[k] * 2 + int'(ser_in)) & mask;  m_so[k] = msb; end
                default: begin m_cnt[k] = m_cnt[k] / 2 + int'(ser_in) * top;   m_so[k] = lsb; end
            endcase
            m_adv[k]++;
            m_wrap[k] = (m_adv[k] % w == 0) ? 1 : 0;
        end else begin
            m_wrap[k] = 0;
        end
    endfunction

    task automatic drive(input bit r, input bit l, input bit e,
                         input bit [1:0] md, input bit si, input int unsigned d);
        exp_t x;
        @(negedge clk);
        reset_n = r; load = l; en = e; mode = md; ser_in = si; data = d;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        x.c4 = 4'(m_cnt[0]); x.o4 = m_so[0][0]; x.s4 = 2'(m_adv[0] % 4); x.w4 = m_wrap[0][0];
        x.c5 = 5'(m_cnt[1]); x.o5 = m_so[1][0]; x.s5 = 3'(m_adv[1] % 5); x.w5 = m_wrap[1][0];
        sb.push_back(x);
    endtask

    // Monitor: one registered response per edge, compared just after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("count4",   int'(count4),   int'(mon_e.c4));
            chk("ser_out4", int'(ser_out4), int'(mon_e.o4));
            chk("step4",    int'(step4),    int'(mon_e.s4));
            chk("wrap4",    int'(wrap4),    int'(mon_e.w4));
            chk("count5",   int'(count5),   int'(mon_e.c5));
            chk("ser_out5", int'(ser_out5), int'(mon_e.o5));
            chk("step5",    int'(step5),    int'(mon_e.s5));
            chk("wrap5",    int'(wrap5),    int'(mon_e.w5));
        end
    end

    initial begin
        // Reset for two cycles.
        repeat (2) drive(0, 0, 0, 2'b00, 0, 0);
        // Rotate left four times from 0001.
        repeat (4) drive(1, 0, 1, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        // Load 1011 then rotate right twice.
        drive(1, 1, 0, 2'b00, 0, 32'hB);
        repeat (2) drive(1, 0, 1, 2'b01, 0, 0);
        // Load 0000 then shift left with ser_in=1.
        drive(1, 1, 0, 2'b00, 0, 0);
        repeat (3) drive(1, 0, 1, 2'b10, 1, 0);
        // Load and enable together, then one rotate left.
        drive(1, 1, 1, 2'b11, 1, 32'h9);
        drive(1, 0, 1, 2'b00, 0, 0);
        // Reset in the middle of a run, then count out a full wrap.
        drive(0, 0, 0, 2'b00, 0, 0);
        repeat (3) drive(1, 0, 1, 2'b00, 0, 0);
        drive(0, 1, 1, 2'b10, 1, 32'h6);
        repeat (5) drive(1, 0, 1, 2'b00, 0, 0);
        // Ten consecutive advances with changing modes (two wraps at width 5).
        drive(0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, 2'(i), 1'(i / 3), 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        // Shift right with ser_in toggling.
        for (int i = 0; i < 6; i++) drive(1, 0, 1, 2'b11, 1'(i), 0);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom), 1'($urandom), $urandom);
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/shift_counter.md
SHIFT_COUNTER -- requirements
Module: shift_counter

Interface
REQ-001 Parameter WIDTH, 8, register width in bits; legal range 2..32.
REQ-002 Parameter RESET_VALUE, 1, value loaded into count on reset; truncated to WIDTH bits.
REQ-003 Parameter SW, $clog2(WIDTH), width of the step output.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 load  input  1  load data into count this cycle.
REQ-007 data  input  WIDTH  parallel load value.
REQ-008 en  input  1  advance count one position this cycle.
REQ-009 mode  input  2  00 rotate left, 01 rotate right, 10 shift left with ser_in, 11 shift right with ser_in.
REQ-010 ser_in  input  1  bit inserted at the vacated end in modes 10/11.
REQ-011 count  output  WIDTH  current register value.
REQ-012 ser_out  output  1  bit that left the register on the last enabled shift.
REQ-013 step  output  SW  number of enabled advances since last reset/load, modulo WIDTH.
REQ-014 wrap  output  1  one-cycle pulse marking completion of WIDTH advances.

Function
REQ-015 All outputs registered; no combinational path from any input to any output.
REQ-016 Priority per edge: reset_n low > load > en > hold.
REQ-017 load=1: count<=data, step<=0, ser_out<=0, wrap<=0; en and mode ignored that cycle.
REQ-018 en=1, mode 00: count<={count[WIDTH-2:0],count[WIDTH-1]}, ser_out<=count[WIDTH-1].
REQ-019 en=1, mode 01: count<={count[0],count[WIDTH-1:1]}, ser_out<=count[0].
REQ-020 en=1, mode 10: count<={count[WIDTH-2:0],ser_in}, ser_out<=count[WIDTH-1].
REQ-021 en=1, mode 11: count<={ser_in,count[WIDTH-1:1]}, ser_out<=count[0].
REQ-022 en=1 (no load): step<=step+1 when step<WIDTH-1, else step<=0.
REQ-023 wrap<=1 exactly on the edge where step goes WIDTH-1 -> 0; wrap<=0 on every other edge.
REQ-024 en=0, load=0: count, step, ser_out hold; wrap<=0.
REQ-025 mode may change on any cycle; the new mode applies to that cycle's advance; step is not cleared by a mode change.
REQ-026 Rotate modes preserve popcount(count); shift modes may change it.
REQ-027 Latency: count, ser_out, step, wrap reflect inputs sampled at edge N starting after edge N (one cycle).
REQ-028 Non-power-of-two WIDTH: step never exceeds WIDTH-1.

Reset
REQ-029 reset_n low at an edge: count<=RESET_VALUE[WIDTH-1:0], step<=0, ser_out<=0, wrap<=0, regardless of load/en/mode.
REQ-030 reset_n low mid-sequence discards all progress; the first advance after release counts as step 1.
REQ-031 Before the first edge with reset_n low, outputs are undefined; bench shall apply reset for >= 2 cycles.

Verification (WIDTH=4, RESET_VALUE=1 unless stated)
REQ-032 Reset, then en=1 mode 00 for 4 cycles -> count 0010,0100,1000,0001; wrap=1 only after 4th edge; ser_out=1 after 4th edge.
REQ-033 load data=1011, then en=1 mode 01 for 2 cycles -> count 1101 then 1110; ser_out 1 then 1; step 1 then 2.
REQ-034 load data=0000, mode 10, ser_in=1 for 3 cycles -> count 0001,0011,0111; ser_out 0 each cycle.
REQ-035 Simultaneous load=1 and en=1 with data=1001 -> count=1001, step=0, wrap=0; next en cycle mode 00 -> count 0011, ser_out 1.
REQ-036 Run 3 enabled advances, assert reset_n=0 with en=1 for one cycle -> count=0001, step=0, wrap=0; 4 further advances needed to see wrap.
REQ-037 WIDTH=5: 10 consecutive enabled advances -> wrap pulses after 5th and 10th edges only, step sequence 1,2,3,4,0,1,2,3,4,0.
